// File: rtl/serial_frame_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one serial line among four requesters.
// Each granted requester gets one frame: start, port, length, L nibbles, stop.
module serial_frame_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] len_in,
  input  logic [NUM_REQ*4-1:0]     data_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       data_rd,
  output logic                     SE_out,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PORT_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [PORT_W-1:0] gsel, gsel_n;
  logic [PORT_W-1:0] ptr, ptr_n;
  logic [PORT_W-1:0] win, idx;
  logic              found;
  logic [LEN_W-1:0]  len_q, len_n, len_sel;
  logic [LEN_W-1:0]  nib_left, nib_left_n;
  logic [3:0]        shreg, shreg_n, cur_nib;
  logic              strobe;
  logic              se_q, se_n;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr + PORT_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Select the winner's length and the granted requester's current nibble.
  always_comb begin
    len_sel = '0;
    cur_nib = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PORT_W'(k) == win)  len_sel = len_in[k*LEN_W +: LEN_W];
      if (PORT_W'(k) == gsel) cur_nib = data_in[k*4 +: 4];
    end
  end

  // Next-state logic; also computes the next field registers and read strobe.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gsel_n     = gsel;
    ptr_n      = ptr;
    len_n      = len_q;
    nib_left_n = nib_left;
    shreg_n    = shreg;
    strobe     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = START;
          gsel_n  = win;
          len_n   = len_sel;
          ptr_n   = win + PORT_W'(1);
          cnt_n   = '0;
        end
      end
      START: begin
        state_n = PORT;
        cnt_n   = '0;
      end
      PORT: begin
        if (cnt == 2'd1) begin
          state_n = LEN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      LEN: begin
        if (cnt == 2'd3) begin
          cnt_n = '0;
          if (len_q != '0) begin
            state_n    = DATA;
            nib_left_n = len_q;
            strobe     = 1'b1;
            shreg_n    = cur_nib;
          end else begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      DATA: begin
        if (cnt == 2'd3) begin
          cnt_n = '0;
          if (nib_left == LEN_W'(1)) begin
            state_n = STOP;
          end else begin
            nib_left_n = nib_left - LEN_W'(1);
            strobe     = 1'b1;
            shreg_n    = cur_nib;
          end
        end else begin
          cnt_n   = cnt + 2'd1;
          shreg_n = {shreg[2:0], 1'b0};
        end
      end
      STOP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Line value for the coming cycle, derived from next-state values so SE_out is a flop.
  always_comb begin
    se_n = 1'b1;
    case (state_n)
      START:   se_n = 1'b0;
      PORT:    se_n = gsel_n[~cnt_n[0]];
      LEN:     se_n = len_n[~cnt_n];
      DATA:    se_n = shreg_n[3];
      default: se_n = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gsel     <= '0;
      ptr      <= '0;
      len_q    <= '0;
      nib_left <= '0;
      shreg    <= '0;
      se_q     <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      gsel     <= gsel_n;
      ptr      <= ptr_n;
      len_q    <= len_n;
      nib_left <= nib_left_n;
      shreg    <= shreg_n;
      se_q     <= se_n;
    end
  end

  // One-hot grant while busy; read strobe routed to the granted requester.
  always_comb begin
    grant   = '0;
    data_rd = '0;
    if (state != IDLE) grant[gsel] = 1'b1;
    if (strobe)        data_rd[gsel] = 1'b1;
  end

  assign SE_out     = se_q;
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP);

endmodule

// File: tb/tb_serial_frame_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench: expected frames are queued when requests are driven and
// checked bit by bit as the arbiter serialises them.
module tb_serial_frame_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] len_in = '0;
  logic [15:0] data_in = '0;
  logic [3:0]  grant, data_rd;
  logic        SE_out, busy, frame_done;

  serial_frame_arbiter #(.NUM_REQ(4), .LEN_W(4)) dut (
    .clock(clock), .rst(rst), .req(req), .len_in(len_in), .data_in(data_in),
    .grant(grant), .data_rd(data_rd), .SE_out(SE_out), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  port;
    logic [3:0]  len;
    logic [63:0] data;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      cur;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  nibs [4][16];
  int unsigned nidx [4];
  int unsigned mnidx [4];
  logic [3:0]  lens [4];
  logic [1:0]  mptr = '0;
  logic [3:0]  prev_rd = '0;
  bit          in_frame = 1'b0;
  int          pos = 0;
  int          last = 0;
  int          started = 0;
  int          cyc = 0;
  int          start_cyc[$];
  int          got_port[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic ebit(input frame_t f, input int p);
    logic [63:0] s;
    int n, b;
    if (p == 0) return 1'b0;
    if (p <= 2) begin s = 64'(f.port) >> (2 - p); return s[0]; end
    if (p <= 6) begin s = 64'(f.len) >> (6 - p); return s[0]; end
    if (p < 7 + 4 * int'(f.len)) begin
      n = (p - 7) / 4;
      b = 3 - ((p - 7) % 4);
      s = f.data >> (4 * n + b);
      return s[0];
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_rd(input frame_t f, input int p);
    if (p >= 6 && ((p - 6) % 4) == 0 && ((p - 6) / 4) < int'(f.len))
      return 4'b0001 << f.port;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] i;
    for (int k = 0; k < 4; k++) begin
      i = p + 2'(k);
      if (r[i]) return i;
    end
    return p;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) data_in[4*i +: 4] = nibs[i][nidx[i] % 16];
  endtask

  task automatic apply_lens();
    for (int i = 0; i < 4; i++) len_in[4*i +: 4] = lens[i];
  endtask

  task automatic new_test();
    for (int i = 0; i < 4; i++) begin
      nidx[i]  = 0;
      mnidx[i] = 0;
    end
    got_port.delete();
    start_cyc.delete();
    apply_lens();
    drive_data();
  endtask

  task automatic push_frames(input logic [3:0] r, input int n);
    frame_t     f;
    logic [1:0] g;
    for (int k = 0; k < n; k++) begin
      g      = arb(r, mptr);
      f.port = g;
      f.len  = lens[g];
      f.data = '0;
      for (int j = 0; j < int'(lens[g]); j++)
        f.data[4*j +: 4] = nibs[g][(mnidx[g] + j) % 16];
      mnidx[g] += lens[g];
      mptr = g + 2'd1;
      exp_q.push_back(f);
    end
  endtask

  task automatic frame_cycle();
    check("se_bit", SE_out, ebit(cur, pos));
    check("grant", grant, 4'b0001 << cur.port);
    check("busy", busy, 1);
    check("data_rd", data_rd, exp_rd(cur, pos));
    check("frame_done", frame_done, pos == last);
    if (pos == last) in_frame = 1'b0;
  endtask

  // One clock: sample after the edge, advance requester nibbles, score outputs.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (prev_rd[i]) nidx[i]++;
    drive_data();
    if (rst) begin
      in_frame = 1'b0;
      check("rst_se", SE_out, 1);
      check("rst_grant", grant, 0);
      check("rst_data_rd", data_rd, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
    end else if (in_frame) begin
      pos++;
      frame_cycle();
    end else if (SE_out == 1'b0) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = '0;
      in_frame = 1'b1;
      pos = 0;
      last = 7 + 4 * int'(cur.len);
      started++;
      start_cyc.push_back(cyc);
      got_port.push_back(onehot_idx(grant));
      frame_cycle();
    end else begin
      check("idle_busy", busy, 0);
      check("idle_grant", grant, 0);
      check("idle_data_rd", data_rd, 0);
      check("idle_frame_done", frame_done, 0);
    end
    prev_rd = rst ? 4'b0000 : data_rd;
  endtask

  task automatic wait_start(input int tgt);
    for (int b = 0; b < 400 && started < tgt; b++) tick();
    check("frames_started", started, tgt);
  endtask

  task automatic wait_idle();
    for (int b = 0; b < 400 && in_frame; b++) tick();
    check("frame_ended", in_frame, 0);
    repeat (3) tick();
  endtask

  task automatic run(input logic [3:0] r, input int n);
    int tgt;
    tgt = started + n;
    req = r;
    wait_start(tgt);
    req = '0;
    wait_idle();
  endtask

  task automatic wait_pos(input int p);
    for (int b = 0; b < 400 && !(in_frame && pos >= p); b++) tick();
    check("reached_pos", pos, p);
  endtask

  initial begin
    int tgt;
    int base;
    for (int i = 0; i < 4; i++) begin
      lens[i] = 4'd1;
      for (int k = 0; k < 16; k++) nibs[i][k] = 4'(i * 5 + k * 3 + 1);
    end
    new_test();

    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = '0;
    repeat (2) tick();

    // Single frame: requester 0, L=2, nibbles A then 5
    nibs[0][0] = 4'hA;
    nibs[0][1] = 4'h5;
    lens[0] = 4'd2;
    new_test();
    push_frames(4'b0001, 1);
    tgt = started + 1;
    req = 4'b0001;
    tick();
    check("start_latency_se", SE_out, 0);
    check("start_latency_grant", grant, 4'b0001);
    wait_start(tgt);
    req = '0;
    wait_idle();

    // Zero-length frame from requester 2
    lens[2] = 4'd0;
    new_test();
    push_frames(4'b0100, 1);
    run(4'b0100, 1);

    // Round-robin fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = '0;
    tick();
    for (int i = 0; i < 4; i++) lens[i] = 4'd1;
    new_test();
    push_frames(4'b1111, 5);
    run(4'b1111, 5);
    check("rr_count", got_port.size(), 5);
    for (int k = 0; k < 5 && k < got_port.size(); k++)
      check("rr_port", got_port[k], k % 4);
    for (int k = 1; k < start_cyc.size(); k++)
      check("rr_period", start_cyc[k] - start_cyc[k-1], 13);

    // Pointer wrap and skip: pointer now at 1
    new_test();
    push_frames(4'b1001, 3);
    run(4'b1001, 3);
    check("wrap_count", got_port.size(), 3);
    if (got_port.size() == 3) begin
      check("wrap_port0", got_port[0], 3);
      check("wrap_port1", got_port[1], 0);
      check("wrap_port2", got_port[2], 3);
    end

    // Request dropped during DATA: frame completes, no re-grant
    lens[1] = 4'd2;
    nibs[1][0] = 4'h3;
    nibs[1][1] = 4'hC;
    new_test();
    push_frames(4'b0010, 1);
    base = started;
    req = 4'b0010;
    wait_pos(8);
    req = '0;
    wait_idle();
    repeat (12) tick();
    check("drop_single_grant", started, base + 1);

    // Reset in the third LEN cycle, then all requesters compete
    lens[2] = 4'd3;
    new_test();
    push_frames(4'b0100, 1);
    req = 4'b0100;
    wait_pos(5);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check("midrst_se", SE_out, 1);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    mptr = '0;
    new_test();
    push_frames(4'b1111, 1);
    run(4'b1111, 1);
    check("post_rst_count", got_port.size(), 1);
    if (got_port.size() != 0) check("post_rst_port", got_port[0], 0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_arbiter.md
# serial_frame_arbiter

Round-robin scheduler that shares the single serial line feeding the serial demux among four requesters. Each requester asks for a frame carrying N data nibbles; the block grants one requester at a time and drives the framed bit stream onto `SE_out`, which connects directly to the demux serial input. The demux port number encoded in each frame equals the index of the granted requester.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4 because the port field is 2 bits.
- `LEN_W`, 4: width of the length field; gives a maximum of 15 nibbles per frame.
- `clock` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `req` in 4: `req[i]` high means requester i has a frame pending. Level-sensitive.
- `len_in` in 16: `len_in[4i+:4]` is the nibble count L (0..15) for requester i. Sampled only at the arbitration edge.
- `data_in` in 16: `data_in[4i+:4]` is the current nibble from requester i. Captured when `data_rd[i]` is high.
- `grant` out 4: one-hot grant, held for the whole frame.
- `data_rd` out 4: one-cycle strobe. `data_in[4g+:4]` is captured at the edge ending this cycle; the requester then advances to its next nibble.
- `SE_out` out 1: serial frame line. Driven from a flop. Idle level is 1.
- `busy` out 1: high when the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse in the STOP cycle.

## Operation
- Frame format on `SE_out`, MSB first:
  - start bit 0;
  - port[1:0];
  - len[3:0];
  - L nibbles of data, each 4 bits;
  - stop bit 1.
- FSM states and the value driven on `SE_out` in each:
  - IDLE: `SE_out`=1.
  - START: 1 cycle, `SE_out`=0.
  - PORT: 2 cycles.
  - LEN: 4 cycles.
  - DATA: 4L cycles.
  - STOP: 1 cycle, `SE_out`=1.
- State transitions:
  - IDLE → START when `|req` is high.
  - START → PORT → LEN.
  - LEN → DATA if L≠0, otherwise LEN → STOP.
  - DATA → STOP after 4L bits.
  - STOP → IDLE, always. IDLE lasts at least one cycle between frames.
- Arbitration happens at the IDLE→START edge:
  - Winner g is the first requester with `req` high, searching from `ptr` upward and wrapping (ptr, ptr+1, …, mod 4).
  - At that edge the block latches g and `len_in[4g+:4]`, and sets `ptr` = (g+1) mod 4.
  - `ptr` resets to 0.
- `data_rd[g]` is asserted in the cycle immediately before each nibble's first bit:
  - the last LEN cycle;
  - the 4th bit cycle of nibble n, for n < L.
  - Exactly L strobes per frame; none when L=0.
  - The captured nibble is loaded into a 4-bit shift register that drives the data bits.
- Changes to `req`, `len_in` or `data_in` after arbitration do not affect the frame in progress, except for `data_in` captured on a strobe.
  - Dropping `req` mid-frame does not abort the frame.
  - A requester still holding `req` after its frame competes again at the next IDLE cycle.
- Reset values: `SE_out`=1, `grant`=0, `data_rd`=0, `busy`=0, `frame_done`=0, state=IDLE, `ptr`=0.
- Reset mid-frame:
  - The next cycle shows the reset values above.
  - The partial frame is abandoned with no stop bit; the line simply returns high.
  - No `data_rd` strobe is issued after reset.

## Timing
- Latency:
  - `req` is high in IDLE during cycle t.
  - START (`SE_out`=0) and `grant` appear in cycle t+1.
  - The port bits appear in cycles t+2 and t+3.
- Frame duration, START through STOP: 8+4L cycles.
- Back-to-back frame period with continuous requests: 9+4L cycles. This includes one IDLE cycle.
- Signal extents:
  - `grant` and `busy` are high from START through STOP inclusive.
  - `frame_done` is high in STOP only.
- When all four `req` are high continuously, grants cycle 0,1,2,3,0,…

## Test plan
- Single frame:
  - Stimulus: after reset, `req`=0001, L=2, nibbles A then 5.
  - Expected `SE_out` from START: 0,00,0010,1010,0101,1.
  - `data_rd[0]` pulses twice, in the 7th cycle and the 11th cycle after START.
  - `frame_done` pulses once, in cycle 16.
- Zero length:
  - Stimulus: `req`=0100, L=0.
  - Expected `SE_out`: 0,10,0000,1, which is 8 cycles.
  - No `data_rd` strobe; `grant`=0100 for 8 cycles.
- Round-robin fairness:
  - Stimulus: `req`=1111 held, all L=1.
  - Grants go 0,1,2,3,0 with a 13-cycle period.
  - Port fields read 00,01,10,11,00.
- Pointer wrap and skip:
  - Stimulus: `req`=1001 with `ptr` at 1.
  - Grants go 3 first, then 0, then 3.
- Mid-frame request drop:
  - Stimulus: deassert `req[g]` during DATA.
  - The frame completes with correct data and a stop bit.
  - No further grant is given to g.
- Reset mid-frame:
  - Stimulus: assert `rst` in the 3rd LEN cycle.
  - In the next cycle: `SE_out`=1, `grant`=0, `busy`=0.
  - The next frame, with `req`=1111, is granted to requester 0.
